// File: rtl/handshake_rx_fifo.sv
// rtl/handshake_rx_fifo.sv - valid/ready receive FIFO with local accept gate and beat counter
module handshake_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [AW:0]       level,
    output logic [15:0]       beat_cnt
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // s_ready depends only on registered level, so a same-cycle pop never opens a full FIFO
    assign s_ready = !rst && accept_en && (level < FULL_LVL);
    assign m_valid = (level != '0);
    assign m_data  = mem[rd_ptr];
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_rx_fifo.sv
// tb/tb_handshake_rx_fifo.sv - scoreboard bench for handshake_rx_fifo
module tb_handshake_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        accept_en;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [2:0]  level;
    logic [15:0] beat_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    handshake_rx_fifo #(.DATA_W(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .accept_en(accept_en),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .level(level), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected entries are queued at the moment a beat is offered and accepted
    always @(negedge clk) begin
        if (s_valid && s_ready) exp_q.push_back(s_data);
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_data_unexpected: got %0h expected none", m_data);
            end else begin
                check("m_data_order", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        cyc();
        cyc();
        exp_q.delete();
        rst = 1'b0;
        #1;
    endtask

    task automatic push_n(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = first + 8'(i);
            cyc();
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; accept_en = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        cyc();
        cyc();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", s_ready, 1);

        // Single beat, latency one
        push_n(8'hA5, 1);
        check("single_m_valid", m_valid, 1);
        check("single_m_data", m_data, 8'hA5);
        check("single_level", level, 1);
        check("single_beat_cnt", beat_cnt, 1);
        drain(1);
        check("single_drained", m_valid, 0);

        // Fill, overflow attempt, drain in order
        do_reset();
        push_n(8'h01, 4);
        check("full_level", level, 4);
        check("full_s_ready", s_ready, 0);
        push_n(8'h05, 1);
        check("overflow_beat_cnt", beat_cnt, 4);
        check("overflow_level", level, 4);
        drain(4);
        check("fill_drained_level", level, 0);

        // Steady streaming at level 2
        do_reset();
        push_n(8'h10, 2);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h20 + 8'(i);
            cyc();
            check("stream_level", level, 2);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("stream_beat_cnt", beat_cnt, 12);
        drain(2);

        // Full with simultaneous offer and pop: pop only, push next cycle
        do_reset();
        push_n(8'h31, 4);
        s_valid = 1'b1; s_data = 8'h35; m_ready = 1'b1;
        cyc();
        check("full_pop_level", level, 3);
        check("full_pop_beat_cnt", beat_cnt, 4);
        m_ready = 1'b0;
        cyc();
        s_valid = 1'b0;
        check("full_push_level", level, 4);
        check("full_push_beat_cnt", beat_cnt, 5);
        drain(4);

        // Local accept gate closed while draining
        do_reset();
        push_n(8'h41, 2);
        accept_en = 1'b0; s_valid = 1'b1; s_data = 8'h4F;
        #1;
        check("gate_s_ready", s_ready, 0);
        cyc();
        check("gate_level", level, 2);
        drain(2);
        s_valid = 1'b0;
        check("gate_drain_level", level, 0);
        check("gate_beat_cnt", beat_cnt, 2);
        accept_en = 1'b1;

        // Reset mid-operation discards entries and coincident traffic
        do_reset();
        push_n(8'h51, 3);
        check("pre_rst_level", level, 3);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h66; m_ready = 1'b1;
        cyc();
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_level", level, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_beat_cnt", beat_cnt, 0);
        push_n(8'h7E, 1);
        check("post_rst_m_data", m_data, 8'h7E);
        drain(1);

        cyc();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
